// File: rtl/arp_resolver_pkg.sv
// Shared types and constants for the ARP resolver: FSM state encoding,
// broadcast address/MAC constants and the single-entry cache record.
package arp_vlg_pkg;

  typedef enum logic [2:0] {
    RSV_IDLE,
    RSV_CHECK,
    RSV_LOOKUP,
    RSV_WAIT,
    RSV_RETRY
  } rsv_fsm_t;

  localparam logic [31:0] BCAST_IPV4 = 32'hFFFF_FFFF;
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  // Age is kept 32 bits wide so any practical CACHE_TICKS fits.
  typedef struct packed {
    logic        val;
    logic [31:0] ipv4;
    logic [47:0] mac;
    logic [31:0] age;
  } arp_cache_entry_t;

endpackage

// File: rtl/arp_resolver_cache.sv
// One-entry IPv4->MAC result cache. An entry lives for CACHE_TICKS cycles
// after a fill; flush wins over a simultaneous fill. Hit is combinational.
module arp_resolver_cache
  import arp_vlg_pkg::*;
#(
  parameter int CACHE_TICKS = 125000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic [31:0] fill_ipv4,
  input  logic [47:0] fill_mac,
  input  logic        flush,
  input  logic [31:0] look_ipv4,
  output logic        hit,
  output logic [47:0] hit_mac
);

  arp_cache_entry_t entry;

  // Fill, flush and age the entry; it drops out once its age runs down to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry <= '0;
    end else if (flush) begin
      entry.val <= 1'b0;
      entry.age <= '0;
    end else if (fill) begin
      entry <= '{val: 1'b1, ipv4: fill_ipv4, mac: fill_mac, age: 32'(CACHE_TICKS)};
    end else if (entry.val) begin
      if (entry.age <= 32'd1) begin
        entry.val <= 1'b0;
        entry.age <= '0;
      end else begin
        entry.age <= entry.age - 32'd1;
      end
    end
  end

  // Lookup compares against the (possibly gateway-substituted) target.
  always_comb begin
    hit     = entry.val && (entry.ipv4 == look_ipv4);
    hit_mac = entry.mac;
  end

endmodule

// File: rtl/arp_resolver.sv
// ARP resolver, initiator side of the ARP table lookup interface.
// Resolves an IPv4 destination to a MAC via a one-entry cache or the ARP
// table, retrying on timeout/no-entry and reporting an error when exhausted.
// Optional macro ARP_RSV_GATEWAY_EN: off-subnet targets resolve the gateway.
module arp_resolver
  import arp_vlg_pkg::*;
#(
  parameter int    TIMEOUT_TICKS = 125000,
  parameter int    RETRIES       = 3,
  parameter int    CACHE_TICKS   = 125000000,
  parameter bit    VERBOSE       = 1,
  parameter string DUT_STRING    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rsv_req,
  input  logic [31:0] rsv_ipv4,
  output logic        rsv_val,
  output logic [47:0] rsv_mac,
  output logic        rsv_err,
  output logic        rsv_busy,
  input  logic [31:0] dev_ipv4,
  input  logic [31:0] dev_mask,
  input  logic [31:0] dev_gw,
  output logic        tbl_req,
  output logic [31:0] tbl_ipv4,
  input  logic        tbl_val,
  input  logic [47:0] tbl_mac,
  input  logic        tbl_err,
  input  logic        flush
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  // The LOOKUP and RETRY cycles are part of the timeout window, so successive
  // table requests sit exactly TIMEOUT_TICKS+1 cycles apart.
  localparam logic [TO_W-1:0] TO_LOAD = (TIMEOUT_TICKS > 0) ? TO_W'(TIMEOUT_TICKS - 1) : '0;
  localparam int RT_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(RETRIES);

  // Message controls only matter to simulation wrappers; RTL emits nothing.
  localparam bit unused_verbose = VERBOSE;
  localparam bit unused_tag     = (DUT_STRING == "");

  rsv_fsm_t        state, state_next;
  logic [31:0]     tgt_ip;
  logic [31:0]     lookup_ip;
  logic [TO_W-1:0] to_cnt;
  logic [RT_W-1:0] rt_cnt;
  logic            is_zero, is_bcast;
  logic            cache_hit;
  logic [47:0]     cache_mac;
  logic            done_val, done_err;
  logic [47:0]     done_mac;

  assign is_zero  = (tgt_ip == '0);
  assign is_bcast = (tgt_ip == BCAST_IPV4);

`ifdef ARP_RSV_GATEWAY_EN
  // Off-subnet unicast targets are reached through the gateway's MAC.
  always_comb begin
    lookup_ip = tgt_ip;
    if (((tgt_ip & dev_mask) != (dev_ipv4 & dev_mask)) && !is_bcast)
      lookup_ip = dev_gw;
  end
`else
  logic unused_dev;
  assign unused_dev = ^{dev_ipv4, dev_mask, dev_gw};
  // Without gateway support every target is looked up as-is.
  always_comb begin
    lookup_ip = tgt_ip;
  end
`endif

  arp_resolver_cache #(
    .CACHE_TICKS(CACHE_TICKS)
  ) u_cache (
    .clk      (clk),
    .rst      (rst),
    .fill     ((state == RSV_WAIT) && tbl_val),
    .fill_ipv4(tbl_ipv4),
    .fill_mac (tbl_mac),
    .flush    (flush),
    .look_ipv4(lookup_ip),
    .hit      (cache_hit),
    .hit_mac  (cache_mac)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RSV_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; tbl_val outranks tbl_err and timeout in WAIT.
  always_comb begin
    state_next = state;
    case (state)
      RSV_IDLE:   if (rsv_req) state_next = RSV_CHECK;
      RSV_CHECK:  state_next = (is_zero || is_bcast || cache_hit) ? RSV_IDLE : RSV_LOOKUP;
      RSV_LOOKUP: state_next = RSV_WAIT;
      RSV_WAIT: begin
        if (tbl_val)                          state_next = RSV_IDLE;
        else if (tbl_err || (to_cnt <= TO_W'(1))) state_next = RSV_RETRY;
      end
      RSV_RETRY:  state_next = (rt_cnt < RT_MAX) ? RSV_LOOKUP : RSV_IDLE;
      default:    state_next = RSV_IDLE;
    endcase
  end

  // Output decode: table request pulse and the result to register next cycle.
  always_comb begin
    tbl_req  = (state == RSV_LOOKUP);
    done_val = 1'b0;
    done_err = 1'b0;
    done_mac = '0;
    case (state)
      RSV_CHECK: begin
        if (is_zero) begin
          done_err = 1'b1;
        end else if (is_bcast) begin
          done_val = 1'b1;
          done_mac = BCAST_MAC;
        end else if (cache_hit) begin
          done_val = 1'b1;
          done_mac = cache_mac;
        end
      end
      RSV_WAIT: begin
        if (tbl_val) begin
          done_val = 1'b1;
          done_mac = tbl_mac;
        end
      end
      RSV_RETRY: begin
        if (!(rt_cnt < RT_MAX)) done_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latch, lookup address, timeout/retry counters and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_ip   <= '0;
      tbl_ipv4 <= '0;
      to_cnt   <= '0;
      rt_cnt   <= '0;
      rsv_busy <= 1'b0;
    end else begin
      if ((state == RSV_IDLE) && rsv_req) begin
        tgt_ip   <= rsv_ipv4;
        rsv_busy <= 1'b1;
      end
      if (state == RSV_CHECK) begin
        tbl_ipv4 <= lookup_ip;
        rt_cnt   <= '0;
      end
      if (state == RSV_LOOKUP)
        to_cnt <= TO_LOAD;
      else if ((state == RSV_WAIT) && (to_cnt != '0))
        to_cnt <= to_cnt - TO_W'(1);
      if ((state == RSV_RETRY) && (rt_cnt < RT_MAX))
        rt_cnt <= rt_cnt + RT_W'(1);
      if (done_val || done_err)
        rsv_busy <= 1'b0;
    end
  end

  // Registered result pulses; MAC reads zero whenever rsv_val is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsv_val <= 1'b0;
      rsv_err <= 1'b0;
      rsv_mac <= '0;
    end else begin
      rsv_val <= done_val;
      rsv_err <= done_err;
      rsv_mac <= done_mac;
    end
  end

endmodule

// File: doc/arp_resolver.md
Name: arp_resolver

Overview:
- Initiator side of the ARP table lookup interface.
- Sits in the IPv4 transmit path: takes a destination IPv4 address from the upper layer and queries the ARP table, which may trigger an ARP request on the wire.
- Waits for the answer, retrying on timeout, and returns the destination MAC or an error.
- Holds a one-entry result cache so back-to-back packets to the same host skip the table.

Parameters:
- TIMEOUT_TICKS, 125000: clock cycles to wait for a table response before one retry.
- RETRIES, 3: table requests issued after the first one before reporting an error.
- CACHE_TICKS, 125000000: cycles a cached entry stays valid after being filled.
- VERBOSE, 1: enables simulation $display messages.
- DUT_STRING, "": prefix for those messages.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rsv_req  in  1  upper-layer resolve request, single-cycle pulse
- rsv_ipv4  in  32  address to resolve, sampled with rsv_req
- rsv_val  out  1  resolve succeeded, one-cycle pulse
- rsv_mac  out  48  resolved MAC, valid while rsv_val=1
- rsv_err  out  1  resolve failed, one-cycle pulse
- rsv_busy  out  1  high from accepted request until rsv_val/rsv_err
- dev_ipv4  in  32  local address
- dev_mask  in  32  subnet mask
- dev_gw  in  32  gateway address
- tbl_req  out  1  table lookup request, one-cycle pulse
- tbl_ipv4  out  32  address to look up, held stable while busy
- tbl_val  in  1  table response valid, pulse
- tbl_mac  in  48  MAC returned with tbl_val
- tbl_err  in  1  table reports no entry (request outstanding)
- flush  in  1  invalidate cache

Behaviour:
- Reset values: all outputs 0; cache invalid; FSM in IDLE.
- Reset mid-operation aborts the resolve with no rsv_val or rsv_err.
- FSM states and transitions:
  - IDLE: rsv_req latches the target address, sets busy, goes to CHECK. rsv_req while busy is ignored; the upper layer must wait for busy low.
  - CHECK (1 cycle):
    - target 255.255.255.255 gives rsv_mac=FF:FF:FF:FF:FF:FF and rsv_val next cycle;
    - cache valid and cache_ip==target gives the cached MAC;
    - otherwise go to LOOKUP.
  - Hit latency is exactly 2 cycles (rsv_req at cycle 0, rsv_val at cycle 2).
  - LOOKUP: pulse tbl_req, reload the timeout counter, go to WAIT.
  - WAIT:
    - tbl_val fills the cache (ip, mac, age=CACHE_TICKS) and pulses rsv_val with tbl_mac the next cycle, then IDLE;
    - tbl_err or counter reaching 0 goes to RETRY.
  - RETRY:
    - if retry count < RETRIES, increment and return to LOOKUP;
    - else pulse rsv_err and go to IDLE.
- Precedence: if tbl_val and tbl_err arrive in the same cycle, tbl_val wins. tbl_val arriving outside WAIT is ignored.
- Timeout counter width is $clog2(TIMEOUT_TICKS+1); retry counter width is $clog2(RETRIES+1).
- Cache age decrements every cycle and the cache invalidates at 0.
- flush invalidates the cache immediately. A flush in the same cycle as a fill leaves the cache invalid.
- Failed resolves never fill the cache.
- rsv_busy deasserts in the same cycle rsv_val or rsv_err is high.
- Address 0.0.0.0 is treated as an error: rsv_err 2 cycles after the request, no table access.

Optional Feature:
- ARP_RSV_GATEWAY_EN defined: in CHECK, a target with (target & dev_mask) != (dev_ipv4 & dev_mask) and not broadcast is replaced by dev_gw for the cache compare and the table lookup.
- Undefined: dev_mask and dev_gw are ignored and every target is looked up directly.

Decomposition:
- Package arp_vlg_pkg:
  - rsv_fsm_t enum;
  - BCAST_IPV4 and BCAST_MAC constants;
  - a cache entry struct {val, ipv4, mac, age}.
- One natural sub-module: arp_resolver_cache (single entry, fill/flush/age/lookup, combinational hit output).

Test Plan:
- Broadcast: rsv_req with 255.255.255.255 -> rsv_val at cycle 2, rsv_mac FF:FF:FF:FF:FF:FF, tbl_req never asserted.
- Miss then hit:
  - request 192.168.1.10; table answers 02:00:00:00:00:0A after 50 cycles -> rsv_val with that MAC, one tbl_req;
  - repeat request -> rsv_val at cycle 2, no tbl_req.
- Timeout: TIMEOUT_TICKS=100, RETRIES=3, no response -> 4 tbl_req pulses 101 cycles apart, then rsv_err; cache stays invalid.
- Aging and flush:
  - CACHE_TICKS=1000: after fill, request at +1001 cycles -> new tbl_req;
  - flush pulse -> next request misses.
- Gateway (macro on): dev 192.168.1.2/255.255.255.0, gw 192.168.1.1, request 8.8.8.8 -> tbl_ipv4=192.168.1.1.
- Gateway (macro off): same request -> tbl_ipv4=8.8.8.8.
- Reset mid-WAIT: rst asserted -> all outputs 0 asynchronously, no rsv_val or rsv_err afterwards; a late tbl_val is ignored.
